lsu_dmem: RTL
=============

Name: lsu_dmem

Overview:
- Parametrised data-memory load/store unit for the rv32i core; successor to the word-only data BRAM path.
- Adds byte/halfword/word stores via byte enables, signed/unsigned sub-word loads, a valid/ready request/response handshake, misalignment trapping, and a dedicated preload port that replaces the external init mux.
- Sits in the memory stage between ALU result/rs2 and the write-back mux.

Parameters:
- DATA_WIDTH, 32, data word width; fixed at 32, four byte lanes.
- ADDR_WIDTH, 12, byte-address width; depth is 2**(ADDR_WIDTH-2) words.
- RSP_HOLD, 1, when 1 the response is held until rsp_ready; when 0 rsp_valid is a single-cycle pulse and rsp_ready is ignored.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_func3  in  3  width/sign code using the RV32I load/store funct3 encoding.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned (rs2).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  DATA_WIDTH  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  out  1  misaligned access or illegal funct3.
- init_valid  in  1  preload word-write request.
- init_ready  out  1  preload accepted; asserted when state is IDLE.
- init_addr  in  ADDR_WIDTH-2  preload word index.
- init_data  in  DATA_WIDTH  preload word.
- debug_addr  in  ADDR_WIDTH  byte address for the debug read; bits [1:0] are ignored.
- debug_data  out  DATA_WIDTH  combinational word read for benches.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, RD (memory read in flight), RSP (response presented).
- Reset (rst=0, async): state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0. Memory contents are not cleared.
- req_ready = (state==IDLE) && !init_valid. The preload port has priority over the core port.
- Preload: an init_valid write in IDLE writes the full word at init_addr at that edge. It is single-cycle, no response, and the state stays IDLE.
- Legal funct3 for loads: LB 000, LH 001, LW 010, LBU 100, LHU 101. Any other code is illegal.
- Legal funct3 for stores: SB 000, SH 001, SW 010. Any other code is illegal.
- Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0.
- Accept edge for a legal store: byte-enabled write at the same edge.
  - SB: lane addr[1:0] gets wdata[7:0].
  - SH: lanes {addr[1],0}/{addr[1],1} get wdata[15:0].
  - SW: all lanes.
  - Next state RSP with rdata=0, err=0. Latency is 1 cycle.
- Accept edge for a legal load: word index latched, next state RD.
  - The RD edge registers the memory word, then lane select and extension: LB/LH sign-extend, LBU/LHU zero-extend.
  - Next state RSP. Latency is 2 cycles from accept to rsp_valid.
- Accept edge for an illegal or misaligned request: no memory access (a store must not write). Next state RSP with err=1, rdata=0.
- RSP with RSP_HOLD=1: outputs stable until rsp_ready=1, then IDLE. rsp_valid drops the cycle after the handshake. No back-to-back accept in the same cycle as the response handshake.
- RSP with RSP_HOLD=0: one-cycle pulse, then IDLE.
- rsp_valid=1 only in RSP. rsp_rdata/rsp_err are held at their last values outside RSP and are cleared only by reset.
- Reset asserted mid-RD or mid-RSP: transaction dropped, no response. A store already committed at its accept edge stays written.
- Load immediately after a store to the same word returns the new data; the write precedes the read by at least one edge, so no forwarding logic is needed.
- Address wrap: none. ADDR_WIDTH exactly spans memory, and upper index bits select the word directly.

Test Plan:
- Preload words 0..3 = 11223344, 55667788, 99AABBCC, DDEEFF00; LW addr 0x8 -> rsp_valid 2 cycles after accept, rdata=99AABBCC, err=0.
- LB addr 0x9 -> FFFFFFBB; LBU addr 0x9 -> 000000BB; LH addr 0xA -> FFFF99AA; LHU addr 0x6 -> 00005566.
- SB addr 0x1 wdata 000000A5, then SH addr 0x6 wdata 0000BEEF -> debug_data @0x0 = 1122A544, @0x4 = BEEF7788; store rsp after 1 cycle, rdata=0.
- SW addr 0xE and LH addr 0x3 -> rsp_err=1, rdata=0, word 0xC unchanged (DDEEFF00); funct3=011 load -> err=1.
- RSP_HOLD=1 with rsp_ready held low 5 cycles -> rsp_valid/rdata stable, req_ready=0, busy=1; rsp_ready=1 -> IDLE next cycle. init_valid and req_valid asserted together -> init written, req_ready=0 that cycle, req accepted next cycle.
- Assert rst=0 during RD of LW 0x4 -> rsp_valid=0 immediately, state IDLE; after release, LW 0x4 -> 55667788.

Source files
------------

// File: rtl/lsu_dmem.sv
// rtl/lsu_dmem.sv - rv32i data-memory load/store unit with preload and debug ports
module lsu_dmem #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12,
   parameter int RSP_HOLD   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_func3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   input  logic                  init_valid,
   output logic                  init_ready,
   input  logic [ADDR_WIDTH-3:0] init_addr,
   input  logic [DATA_WIDTH-1:0] init_data,
   input  logic [ADDR_WIDTH-1:0] debug_addr,
   output logic [DATA_WIDTH-1:0] debug_data,
   output logic                  busy
);

   localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      RSP  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-3:0]   idx_q, idx_d;
   logic [1:0]              off_q, off_d;
   logic [2:0]              f3_q, f3_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    err_q, err_d;

   logic [DATA_WIDTH-1:0]   mem_q [0:DEPTH-1];

   logic                    f3_legal, misal, req_ok, accept, wr_en;
   logic [3:0]              be;
   logic [DATA_WIDTH-1:0]   wlane;
   logic [DATA_WIDTH-1:0]   rd_word, ld_result;
   logic [7:0]              ld_byte;
   logic [15:0]             ld_half;
   logic                    dbg_unused;

   assign req_ready  = (state_q == IDLE) && !init_valid;
   assign init_ready = (state_q == IDLE);
   assign rsp_valid  = (state_q == RSP);
   assign busy       = (state_q != IDLE);
   assign rsp_rdata  = rdata_q;
   assign rsp_err    = err_q;
   assign accept     = req_valid && req_ready;
   assign debug_data = mem_q[debug_addr[ADDR_WIDTH-1:2]];
   assign dbg_unused = ^debug_addr[1:0];

   // Request decode: funct3 legality, alignment and store lane steering
   always_comb begin
      f3_legal = 1'b0;
      misal    = 1'b0;
      be       = 4'b1111;
      wlane    = req_wdata;
      if (req_we) f3_legal = req_func3 inside {3'b000, 3'b001, 3'b010};
      else        f3_legal = req_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      misal = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
              ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      case (req_func3[1:0])
         2'b00: begin
            be    = 4'b0001 << req_addr[1:0];
            wlane = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            be    = req_addr[1] ? 4'b1100 : 4'b0011;
            wlane = {2{req_wdata[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wlane = req_wdata;
         end
      endcase
   end

   assign req_ok = f3_legal && !misal;
   assign wr_en  = accept && req_we && req_ok;

   // Memory array: preload wins, otherwise byte-enabled store at accept; never reset
   always_ff @(posedge clk) begin
      if (init_valid && (state_q == IDLE)) begin
         mem_q[init_addr] <= init_data;
      end else if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem_q[req_addr[ADDR_WIDTH-1:2]][8*i +: 8] <= wlane[8*i +: 8];
         end
      end
   end

   // Load path: pick the lane out of the latched word and extend it
   always_comb begin
      rd_word = mem_q[idx_q];
      ld_byte = rd_word[{off_q, 3'b000} +: 8];
      ld_half = off_q[1] ? rd_word[31:16] : rd_word[15:0];
      case (f3_q)
         3'b000:  ld_result = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_result = {24'd0, ld_byte};
         3'b001:  ld_result = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_result = {16'd0, ld_half};
         default: ld_result = rd_word;
      endcase
   end

   // Next-state and response register update
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      off_d   = off_q;
      f3_d    = f3_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (!req_ok) begin
                  rdata_d = '0;
                  err_d   = 1'b1;
                  state_d = RSP;
               end else if (req_we) begin
                  rdata_d = '0;
                  err_d   = 1'b0;
                  state_d = RSP;
               end else begin
                  idx_d   = req_addr[ADDR_WIDTH-1:2];
                  off_d   = req_addr[1:0];
                  f3_d    = req_func3;
                  state_d = RD;
               end
            end
         end
         RD: begin
            rdata_d = ld_result;
            err_d   = 1'b0;
            state_d = RSP;
         end
         RSP: begin
            if ((RSP_HOLD == 0) || rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and response registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         off_q   <= '0;
         f3_q    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         off_q   <= off_d;
         f3_q    <= f3_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

endmodule
